// File: rtl/i2c_pkg.sv
// Shared types for the i2c command queue: FSM states and the packed command word.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_DATA_W = 16;
  localparam int CMD_W      = 2 + I2C_ADDR_W + I2C_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_RESP      = 3'd4
  } state_t;

  // Command word as it sits in the FIFO: {rw, two_bytes, addr, data}
  typedef struct packed {
    logic                  rw;
    logic                  two_bytes;
    logic [I2C_ADDR_W-1:0] addr;
    logic [I2C_DATA_W-1:0] data;
  } cmd_t;

endpackage

// File: rtl/i2c_cmd_queue_sync_fifo.sv
// Small synchronous FIFO. The head entry is visible combinationally so the
// consumer can pop it and register its fields in the same cycle.
module sync_fifo #(
  parameter  int WIDTH = 25,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Storage write; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); level tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_level == FULL_LEVEL);
  assign empty = (r_level == '0);
  assign level = r_level;

endmodule

// File: rtl/i2c_cmd_queue.sv
// Command queue in front of the i2c master: buffers requests, launches them one
// at a time on the master's start/ready handshake and returns one response each.
module i2c_cmd_queue
  import i2c_pkg::*;
#(
  parameter  int DEPTH   = 4,
  parameter  int TIMEOUT = 1024,
  localparam int LW      = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_rw,
  input  logic                  cmd_two_bytes,
  input  logic [I2C_ADDR_W-1:0] cmd_addr,
  input  logic [I2C_DATA_W-1:0] cmd_data,
  output logic                  m_start,
  output logic                  m_rw,
  output logic                  m_two_bytes,
  output logic [I2C_ADDR_W-1:0] m_addr,
  output logic [I2C_DATA_W-1:0] m_data,
  input  logic                  m_ready,
  input  logic [I2C_DATA_W-1:0] m_read_data,
  output logic                  rsp_valid,
  output logic                  rsp_rw,
  output logic [I2C_DATA_W-1:0] rsp_data,
  output logic                  rsp_err,
  output logic [LW-1:0]         fifo_level
);

  // Timer counts cycles since the LAUNCH cycle; it expires on its last value.
  localparam int          TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t                r_state, w_state_next;
  logic [TW-1:0]         r_timer, w_timer_next;
  cmd_t                  r_cmd;
  logic                  r_rsp_rw;
  logic [I2C_DATA_W-1:0] r_rsp_data, w_rsp_data_next;
  logic                  r_rsp_err, w_rsp_err_next;
  logic                  w_rsp_load;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  cmd_t                  w_push_word;
  cmd_t                  w_head;

  assign w_push_word = '{rw: cmd_rw, two_bytes: cmd_two_bytes, addr: cmd_addr, data: cmd_data};

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_valid & ~w_full),
    .din   (w_push_word),
    .pop   (w_pop),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (fifo_level)
  );

  // State, timer, launched command and response holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_timer    <= '0;
      r_cmd      <= '0;
      r_rsp_rw   <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_timer_next;
      if (w_pop) r_cmd <= w_head;
      if (w_rsp_load) begin
        r_rsp_rw   <= r_cmd.rw;
        r_rsp_data <= w_rsp_data_next;
        r_rsp_err  <= w_rsp_err_next;
      end
    end
  end

  // Next-state, timer and response decode; completion wins over a same-cycle timeout.
  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = r_timer;
    w_pop           = 1'b0;
    w_rsp_load      = 1'b0;
    w_rsp_data_next = '0;
    w_rsp_err_next  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && m_ready) begin
          w_pop        = 1'b1;
          w_timer_next = '0;
          w_state_next = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        w_timer_next = r_timer + TW'(1);
        w_state_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        w_timer_next = r_timer + TW'(1);
        if (!m_ready) begin
          w_state_next = ST_WAIT_DONE;
        end else if (r_timer == T_LAST) begin
          w_state_next   = ST_RESP;
          w_rsp_load     = 1'b1;
          w_rsp_err_next = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        w_timer_next = r_timer + TW'(1);
        if (m_ready) begin
          w_state_next    = ST_RESP;
          w_rsp_load      = 1'b1;
          w_rsp_data_next = r_cmd.rw ? m_read_data : '0;
        end else if (r_timer == T_LAST) begin
          w_state_next   = ST_RESP;
          w_rsp_load     = 1'b1;
          w_rsp_err_next = 1'b1;
        end
      end
      ST_RESP: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready   = ~w_full;
  assign m_start     = (r_state == ST_LAUNCH);
  assign m_rw        = r_cmd.rw;
  assign m_two_bytes = r_cmd.two_bytes;
  assign m_addr      = r_cmd.addr;
  assign m_data      = r_cmd.data;
  assign rsp_valid   = (r_state == ST_RESP);
  assign rsp_rw      = r_rsp_rw;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Self-checking bench for i2c_cmd_queue: table-driven single transactions,
// multi-cycle corner cases, and a second instance with a short timeout.
module tb_i2c_cmd_queue;
  import i2c_pkg::*;

  localparam int DEPTH    = 4;
  localparam int BUSY_LEN = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Main instance (default timeout) signals
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rw = 1'b0;
  logic        cmd_two_bytes = 1'b0;
  logic [6:0]  cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        m_start, m_rw, m_two_bytes;
  logic [6:0]  m_addr;
  logic [15:0] m_data;
  logic        m_ready;
  logic [15:0] m_read_data;
  logic        rsp_valid, rsp_rw, rsp_err;
  logic [15:0] rsp_data;
  logic [2:0]  fifo_level;

  // Short-timeout instance signals (command fields shared with the main one)
  logic        t_cmd_valid = 1'b0;
  logic        t_cmd_ready;
  logic        t_m_start, t_m_rw, t_m_two_bytes;
  logic [6:0]  t_m_addr;
  logic [15:0] t_m_data;
  logic        t_m_ready = 1'b1;
  logic [15:0] t_m_read_data = 16'h5A5A;
  logic        t_rsp_valid, t_rsp_rw, t_rsp_err;
  logic [15:0] t_rsp_data;
  logic [2:0]  t_fifo_level;

  i2c_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(1024)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_two_bytes(cmd_two_bytes), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .m_start(m_start), .m_rw(m_rw), .m_two_bytes(m_two_bytes), .m_addr(m_addr),
    .m_data(m_data), .m_ready(m_ready), .m_read_data(m_read_data),
    .rsp_valid(rsp_valid), .rsp_rw(rsp_rw), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .fifo_level(fifo_level)
  );

  i2c_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst),
    .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_rw(cmd_rw),
    .cmd_two_bytes(cmd_two_bytes), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .m_start(t_m_start), .m_rw(t_m_rw), .m_two_bytes(t_m_two_bytes), .m_addr(t_m_addr),
    .m_data(t_m_data), .m_ready(t_m_ready), .m_read_data(t_m_read_data),
    .rsp_valid(t_rsp_valid), .rsp_rw(t_rsp_rw), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err),
    .fifo_level(t_fifo_level)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  // ---------------- master model ----------------
  bit          hold = 1'b0;      // bench forces the master to look busy
  bit          mdl_busy = 1'b0;
  int          mdl_cnt = 0;
  logic [15:0] mdl_rd = '0;

  assign m_ready = !mdl_busy && !hold;

  function automatic logic [15:0] rdata_for(input logic [6:0] a);
    case (a)
      7'h48:   return 16'hA7B8;
      7'h1A:   return 16'h1234;
      7'h33:   return 16'hBEEF;
      default: return 16'hDEAD;
    endcase
  endfunction

  // Master goes busy for BUSY_LEN cycles after each start, then presents read data.
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      mdl_busy    = 1'b0;
      mdl_cnt     = 0;
      m_read_data = 16'h0000;
    end else if (m_start) begin
      mdl_busy = 1'b1;
      mdl_cnt  = BUSY_LEN;
      mdl_rd   = rdata_for(m_addr);
    end else if (mdl_busy) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mdl_busy    = 1'b0;
        m_read_data = mdl_rd;
      end
    end
  end

  // ---------------- scoreboards / monitor ----------------
  typedef struct packed {
    logic        rw;
    logic [15:0] data;
    logic        err;
  } rsp_t;

  rsp_t rsp_q[$];
  cmd_t launch_q[$];
  rsp_t mon_rsp;
  cmd_t mon_cmd;
  bit   prev_ready = 1'b1;
  int   viol   = 0;
  int   n_launch = 0;
  int   n_rsp  = 0;

  // Sample shortly after the falling edge, once bench drives have settled.
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_ready = 1'b1;
    end else begin
      if (m_start) begin
        n_launch++;
        if (!prev_ready) viol++;
        if (launch_q.size() == 0) begin
          check("unexpected_launch", 32'(m_addr), 32'h0000_FFFF);
        end else begin
          mon_cmd = launch_q.pop_front();
          check("launch_fields", 32'({m_rw, m_two_bytes, m_addr, m_data}), 32'(mon_cmd));
        end
      end
      if (rsp_valid) begin
        n_rsp++;
        if (rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_data), 32'h0001_0000);
        end else begin
          mon_rsp = rsp_q.pop_front();
          check("rsp_fields", 32'({rsp_rw, rsp_data, rsp_err}), 32'(mon_rsp));
        end
      end
      prev_ready = m_ready;
    end
  end

  // Drive one command at the current falling edge and wait until it is accepted.
  task automatic push_cmd(input logic rw, input logic two, input logic [6:0] a,
                          input logic [15:0] d, input logic [15:0] exp_d);
    int guard;
    guard = 0;
    cmd_rw = rw; cmd_two_bytes = two; cmd_addr = a; cmd_data = d; cmd_valid = 1'b1;
    while (!cmd_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check("push_accept_timeout", 32'(cmd_ready), 32'd1);
    end else begin
      launch_q.push_back('{rw: rw, two_bytes: two, addr: a, data: d});
      rsp_q.push_back('{rw: rw, data: exp_d, err: 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int guard;
    guard = 0;
    while ((rsp_q.size() != 0 || launch_q.size() != 0) && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    check(name, 32'(rsp_q.size() + launch_q.size()), 32'd0);
  endtask

  typedef struct {
    logic        rw;
    logic        two;
    logic [6:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs[4];
  vec_t bbv[5];

  initial begin
    #500000;
    $display("[TB] FAIL global_watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int l0;
    int c;
    int g;
    int starts;

    vecs[0] = '{1'b0, 1'b0, 7'h50, 16'hAA55, 16'h0000};
    vecs[1] = '{1'b1, 1'b1, 7'h48, 16'h0000, 16'hA7B8};
    vecs[2] = '{1'b0, 1'b1, 7'h22, 16'h1357, 16'h0000};
    vecs[3] = '{1'b1, 1'b0, 7'h1A, 16'h0000, 16'h1234};

    bbv[0] = '{1'b0, 1'b0, 7'h10, 16'h0001, 16'h0000};
    bbv[1] = '{1'b1, 1'b0, 7'h33, 16'h0000, 16'hBEEF};
    bbv[2] = '{1'b0, 1'b1, 7'h11, 16'hF00D, 16'h0000};
    bbv[3] = '{1'b1, 1'b1, 7'h48, 16'h0000, 16'hA7B8};
    bbv[4] = '{1'b1, 1'b0, 7'h1A, 16'h0000, 16'h1234};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_m_outputs", 32'({m_start, m_rw, m_two_bytes, m_addr, m_data}), 32'd0);
    check("rst_rsp_outputs", 32'({rsp_valid, rsp_rw, rsp_data, rsp_err}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven single transactions ----
    for (int i = 0; i < 4; i++) begin
      l0 = n_launch;
      push_cmd(vecs[i].rw, vecs[i].two, vecs[i].addr, vecs[i].data, vecs[i].exp_data);
      cmd_valid = 1'b0;
      wait_drain($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_one_launch", i), 32'(n_launch - l0), 32'd1);
      check($sformatf("vec%0d_m_addr_held", i), 32'(m_addr), 32'(vecs[i].addr));
    end

    // ---- back-to-back pushes while the master is busy ----
    hold = 1'b1;
    l0 = n_launch;
    for (int i = 0; i < 4; i++) begin
      push_cmd(bbv[i].rw, bbv[i].two, bbv[i].addr, bbv[i].data, bbv[i].exp_data);
    end
    check("bb_level_peak", 32'(fifo_level), 32'd4);
    check("bb_ready_when_full", 32'(cmd_ready), 32'd0);
    cmd_rw = bbv[4].rw; cmd_two_bytes = bbv[4].two; cmd_addr = bbv[4].addr;
    cmd_data = bbv[4].data; cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("bb_fifth_waits_level", 32'(fifo_level), 32'd4);
    check("bb_no_launch_while_held", 32'(n_launch - l0), 32'd0);
    hold = 1'b0;
    push_cmd(bbv[4].rw, bbv[4].two, bbv[4].addr, bbv[4].data, bbv[4].exp_data);
    cmd_valid = 1'b0;
    wait_drain("bb_drain");
    check("bb_five_launches", 32'(n_launch - l0), 32'd5);

    // ---- simultaneous push and pop at level 1 ----
    hold = 1'b1;
    push_cmd(1'b0, 1'b0, 7'h2B, 16'h4242, 16'h0000);
    cmd_valid = 1'b0;
    check("pp_level_before", 32'(fifo_level), 32'd1);
    hold = 1'b0;
    push_cmd(1'b1, 1'b1, 7'h48, 16'h0000, 16'hA7B8);
    cmd_valid = 1'b0;
    check("pp_level_kept", 32'(fifo_level), 32'd1);
    check("pp_launch_now", 32'(m_start), 32'd1);
    check("pp_launch_addr", 32'(m_addr), 32'h2B);
    wait_drain("pp_drain");

    // ---- reset while waiting on the master with two entries queued ----
    push_cmd(1'b0, 1'b0, 7'h60, 16'h1111, 16'h0000);
    push_cmd(1'b0, 1'b0, 7'h61, 16'h2222, 16'h0000);
    push_cmd(1'b0, 1'b0, 7'h62, 16'h3333, 16'h0000);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid_pre_level", 32'(fifo_level), 32'd2);
    check("mid_pre_busy", 32'(m_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_m_outputs", 32'({m_start, m_rw, m_two_bytes, m_addr, m_data}), 32'd0);
    check("mid_rst_rsp_outputs", 32'({rsp_valid, rsp_rw, rsp_data, rsp_err}), 32'd0);
    rsp_q.delete();
    launch_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    l0 = n_rsp;
    c  = n_launch;
    repeat (40) @(negedge clk);
    check("mid_no_rsp_after_rst", 32'(n_rsp - l0), 32'd0);
    check("mid_no_launch_after_rst", 32'(n_launch - c), 32'd0);

    // ---- timeout on the TIMEOUT=16 instance ----
    cmd_rw = 1'b1; cmd_two_bytes = 1'b0; cmd_addr = 7'h33; cmd_data = 16'h0000;
    t_cmd_valid = 1'b1;
    @(negedge clk);
    cmd_rw = 1'b0; cmd_two_bytes = 1'b1; cmd_addr = 7'h44; cmd_data = 16'h9999;
    @(negedge clk);
    t_cmd_valid = 1'b0;
    g = 0;
    while (!t_m_start && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("to_first_launch_seen", 32'(t_m_start), 32'd1);
    check("to_first_launch_addr", 32'(t_m_addr), 32'h33);
    t_m_ready = 1'b0;
    c = 0;
    while (!t_rsp_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("to_latency", 32'(c), 32'd16);
    check("to_rsp_fields", 32'({t_rsp_rw, t_rsp_data, t_rsp_err}), 32'({1'b1, 16'h0000, 1'b1}));
    starts = 0;
    repeat (5) begin
      @(negedge clk);
      if (t_m_start) starts++;
    end
    check("to_no_launch_while_busy", 32'(starts), 32'd0);
    check("to_second_queued", 32'(t_fifo_level), 32'd1);
    t_m_ready = 1'b1;
    g = 0;
    while (!t_m_start && g < 10) begin
      @(negedge clk);
      g++;
    end
    check("to_second_launch_seen", 32'(t_m_start), 32'd1);
    check("to_second_launch_fields", 32'({t_m_rw, t_m_two_bytes, t_m_addr, t_m_data}),
          32'({1'b0, 1'b1, 7'h44, 16'h9999}));
    t_m_ready = 1'b0;
    repeat (3) @(negedge clk);
    t_m_ready = 1'b1;
    g = 0;
    while (!t_rsp_valid && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("to_second_rsp", 32'({t_rsp_valid, t_rsp_rw, t_rsp_data, t_rsp_err}),
          32'({1'b1, 1'b0, 16'h0000, 1'b0}));

    // ---- global properties ----
    check("never_launch_while_not_ready", 32'(viol), 32'd0);
    check("scoreboards_empty", 32'(rsp_q.size() + launch_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
